// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header
// Purpose : strips a byte_header_cnt-byte header off the first beat of an
//           AXI-Stream packet onto a header channel, then re-packs the
//           remaining payload into full MSB-justified output beats.
// Latency : a payload beat is valid 1 cycle after the input beat that
//           completes it; the header is valid 1 cycle after the first beat.
// Backpressure: ready_in drops while the payload register is held by
//           ready_out, while the header register is held by ready_header
//           (first beat only), and for the single FLUSH cycle per packet.
//
// Ports:
//   clk, rst                      single clock, async active-high reset
//   valid_in/data_in/keep_in/last_in/ready_in   input stream
//   byte_header_cnt               header length N (0..W), sampled on beat 0
//   valid_header/data_header/keep_header/ready_header   header channel
//   valid_out/data_out/keep_out/last_out/ready_out      payload stream
//   err_keep                      sticky keep-protocol error
//
// Optional feature macro: STRIP_HDR_KEEP_CHECK_EN
//   defined   : err_keep flags non-contiguous / non-MSB-justified keep_in and
//               partial keep on non-last beats (sticky until rst).
//   undefined : err_keep tied to 0, no check logic.

module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     valid_in,
  input  logic [DATA_WD-1:0]       data_in,
  input  logic [DATA_BYTE_WD-1:0]  keep_in,
  input  logic                     last_in,
  output logic                     ready_in,

  input  logic [BYTE_CNT_WD:0]     byte_header_cnt,

  output logic                     valid_header,
  output logic [DATA_WD-1:0]       data_header,
  output logic [DATA_BYTE_WD-1:0]  keep_header,
  input  logic                     ready_header,

  output logic                     valid_out,
  output logic [DATA_WD-1:0]       data_out,
  output logic [DATA_BYTE_WD-1:0]  keep_out,
  output logic                     last_out,
  input  logic                     ready_out,

  output logic                     err_keep
);

  // CW holds a byte count 0..W; TW holds residue + payload, 0..2W-1.
  localparam int CW = BYTE_CNT_WD + 1;
  localparam int TW = BYTE_CNT_WD + 2;

  localparam logic [1:0] ST_HEAD  = 2'd0;
  localparam logic [1:0] ST_BODY  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------
  function automatic logic [CW-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Mask with the top n byte lanes set (byte 0 is the MSB lane).
  function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [TW-1:0] n);
    logic [DATA_BYTE_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      m[DATA_BYTE_WD-1-i] = (n > TW'(i));
    end
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] lanes_to_bits(input logic [DATA_BYTE_WD-1:0] m);
    logic [DATA_WD-1:0] b;
    b = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      b[i*8 +: 8] = {8{m[i]}};
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]          state;
  logic [DATA_WD-1:0]  res_dat;   // residue bytes, MSB-justified, unused lanes 0
  logic [CW-1:0]       res_cnt;   // 0..W-1
  logic                alive;     // holds ready_in low while rst is asserted

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  logic                    is_head;
  logic                    out_free;
  logic                    hdr_free;
  logic                    acc;
  logic [CW-1:0]           hdr_n;
  logic [CW-1:0]           k_cnt;
  logic [CW-1:0]           p_cnt;
  logic [DATA_WD-1:0]      pay_dat;
  logic [TW-1:0]           t_cnt;
  logic [TW-1:0]           t_rem;
  logic                    t_full;
  logic [2*DATA_WD-1:0]    merged;
  logic [DATA_WD-1:0]      merged_hi;
  logic [DATA_WD-1:0]      merged_lo;
  logic [DATA_BYTE_WD-1:0] hdr_mask;

  assign is_head  = (state == ST_HEAD);
  assign out_free = !valid_out || ready_out;
  assign hdr_free = !valid_header || ready_header;
  assign ready_in = alive && (state != ST_FLUSH) && out_free && (!is_head || hdr_free);
  assign acc      = valid_in && ready_in;

  always_comb begin
    hdr_n    = is_head ? byte_header_cnt : '0;
    k_cnt    = popcnt(keep_in);
    // Header longer than the valid bytes leaves no payload in this beat.
    p_cnt    = (k_cnt > hdr_n) ? (k_cnt - hdr_n) : '0;
    // Shift the header out, then clear lanes beyond the payload so that
    // downstream bytes outside keep are always zero.
    pay_dat  = (data_in << {hdr_n, 3'b000}) & lanes_to_bits(top_mask(TW'(p_cnt)));
    t_cnt    = TW'(res_cnt) + TW'(p_cnt);
    t_full   = (t_cnt >= TW'(DATA_BYTE_WD));
    t_rem    = t_cnt - TW'(DATA_BYTE_WD);
    // Residue occupies the top r lanes of a 2W-byte window; payload is
    // appended right after it. The upper W bytes are the candidate output
    // beat, the lower W bytes are the leftover residue.
    merged   = {res_dat, {DATA_WD{1'b0}}} | ({pay_dat, {DATA_WD{1'b0}}} >> {res_cnt, 3'b000});
    merged_hi = merged[2*DATA_WD-1 -: DATA_WD];
    merged_lo = merged[DATA_WD-1:0];
    hdr_mask = top_mask(TW'(byte_header_cnt)) & keep_in;
  end

  // ---------------------------------------------------------------------
  // Control, residue and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_HEAD;
      res_dat      <= '0;
      res_cnt      <= '0;
      alive        <= 1'b0;
      valid_out    <= 1'b0;
      data_out     <= '0;
      keep_out     <= '0;
      last_out     <= 1'b0;
      valid_header <= 1'b0;
      data_header  <= '0;
      keep_header  <= '0;
    end else begin
      alive <= 1'b1;

      // Consumed registers drop valid; a new emit below overrides this.
      if (valid_out && ready_out) begin
        valid_out <= 1'b0;
      end
      if (valid_header && ready_header) begin
        valid_header <= 1'b0;
      end

      if (acc) begin
        if (is_head) begin
          data_header  <= data_in & lanes_to_bits(hdr_mask);
          keep_header  <= hdr_mask;
          valid_header <= 1'b1;
        end

        if (last_in) begin
          if (t_cnt == '0) begin
            // Header-only packet: nothing left for the payload stream.
            state   <= ST_HEAD;
            res_dat <= '0;
            res_cnt <= '0;
          end else if (!t_full || (t_cnt == TW'(DATA_BYTE_WD))) begin
            valid_out <= 1'b1;
            data_out  <= merged_hi;
            keep_out  <= top_mask(t_cnt);
            last_out  <= 1'b1;
            state     <= ST_HEAD;
            res_dat   <= '0;
            res_cnt   <= '0;
          end else begin
            // More than one beat's worth remains: send a full beat now and
            // the leftover from FLUSH once the output register frees.
            valid_out <= 1'b1;
            data_out  <= merged_hi;
            keep_out  <= '1;
            last_out  <= 1'b0;
            state     <= ST_FLUSH;
            res_dat   <= merged_lo;
            res_cnt   <= CW'(t_rem);
          end
        end else begin
          state <= ST_BODY;
          if (t_full) begin
            valid_out <= 1'b1;
            data_out  <= merged_hi;
            keep_out  <= '1;
            last_out  <= 1'b0;
            res_dat   <= merged_lo;
            res_cnt   <= CW'(t_rem);
          end else begin
            res_dat <= merged_hi;
            res_cnt <= CW'(t_cnt);
          end
        end
      end else if ((state == ST_FLUSH) && out_free) begin
        valid_out <= 1'b1;
        data_out  <= res_dat;
        keep_out  <= top_mask(TW'(res_cnt));
        last_out  <= 1'b1;
        res_dat   <= '0;
        res_cnt   <= '0;
        state     <= ST_HEAD;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Keep-protocol checker
  // ---------------------------------------------------------------------
`ifdef STRIP_HDR_KEEP_CHECK_EN
  logic keep_bad;
  logic err_keep_q;

  // A legal keep is exactly the top popcount lanes; non-last beats must be full.
  assign keep_bad = (keep_in != top_mask(TW'(k_cnt))) ||
                    (!last_in && (keep_in != {DATA_BYTE_WD{1'b1}}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_keep_q <= 1'b0;
    end else if (acc && keep_bad) begin
      err_keep_q <= 1'b1;
    end
  end

  assign err_keep = err_keep_q;
`else
  assign err_keep = 1'b0;
`endif

endmodule
